branch_resolve_unit: RTL and testbench

- Execute-side partner of the gshare predictor: records each fetch-time branch prediction in an in-order queue.
- When EX resolves the oldest branch, compares actual outcome against the queued prediction.
- Drives the predictor training interface (update / actual_taken / pc).
- On a mispredict, issues a one-cycle pipeline flush with a redirect PC and holds fetch off for a fixed recovery window.

---
 rtl/branch_resolve_if.sv | 34 +++
 rtl/branch_resolve_unit.sv | 130 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// Fetch-side prediction push, EX-side resolution and predictor-training/redirect
// signals exchanged with the branch resolve unit.
interface branch_resolve_if;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic [31:0] pred_target;
  logic        pred_ready;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic        upd_valid;
  logic        upd_taken;
  logic [31:0] upd_pc;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
  logic        underflow_err;

  modport master (
    output pred_valid, pred_taken, pred_pc, pred_target,
    output res_valid, res_taken, res_target,
    input  pred_ready, upd_valid, upd_taken, upd_pc, flush, redirect_pc,
    input  branch_count, mispredict_count, underflow_err
  );

  modport slave (
    input  pred_valid, pred_taken, pred_pc, pred_target,
    input  res_valid, res_taken, res_target,
    output pred_ready, upd_valid, upd_taken, upd_pc, flush, redirect_pc,
    output branch_count, mispredict_count, underflow_err
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// In-order queue of fetch-time branch predictions; checks them against EX
// resolutions, trains the predictor and redirects fetch on a mispredict.
module branch_resolve_unit #(
  parameter int DEPTH          = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  branch_resolve_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RC_W  = $clog2(RECOVER_CYCLES + 1);

  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [RC_W-1:0]   rc_cnt, rc_cnt_nxt;

  logic              q_taken  [DEPTH];
  logic [31:0]       q_pc     [DEPTH];
  logic [31:0]       q_target [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  occ;

  logic              full, empty, push, pop, mispredict, underflow;

  logic              upd_vld_p1, upd_taken_p1, flush_p1, underflow_p1;
  logic [31:0]       upd_pc_p1, redirect_pc_p1, branch_cnt_p1, mispredict_cnt_p1;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign full           = (occ == CNT_W'(DEPTH));
  assign empty          = (occ == '0);
  assign bus.pred_ready = (state == RUN) && !full;
  assign push           = bus.pred_valid && bus.pred_ready;
  assign pop            = bus.res_valid && (state == RUN) && !empty;
  assign underflow      = bus.res_valid && (state == RUN) && empty;
  assign mispredict     = pop && ((bus.res_taken != q_taken[head]) ||
                                  (bus.res_taken && (bus.res_target != q_target[head])));

  always_comb begin
    state_nxt  = state;
    rc_cnt_nxt = rc_cnt;
    if (state == RUN) begin
      if (mispredict) begin
        state_nxt  = RECOVER;
        rc_cnt_nxt = RC_W'(RECOVER_CYCLES);
      end
    end else begin
      if (rc_cnt <= RC_W'(1)) state_nxt = RUN;
      else                    rc_cnt_nxt = rc_cnt - RC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= RUN;
      rc_cnt <= '0;
    end else begin
      state  <= state_nxt;
      rc_cnt <= rc_cnt_nxt;
    end
  end

  // Younger entries behind a mispredicted branch are wrong-path, so the whole
  // queue is dropped, including any push offered in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (mispredict) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (pop)  head <= head + PTR_W'(1);
      if (push) tail <= tail + PTR_W'(1);
      if (push && !pop)      occ <= occ + CNT_W'(1);
      else if (pop && !push) occ <= occ - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_taken[tail]  <= bus.pred_taken;
      q_pc[tail]     <= bus.pred_pc;
      q_target[tail] <= bus.pred_target;
    end
  end

  // Stage p1: registered resolution results
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upd_vld_p1        <= 1'b0;
      upd_taken_p1      <= 1'b0;
      upd_pc_p1         <= '0;
      flush_p1          <= 1'b0;
      redirect_pc_p1    <= '0;
      branch_cnt_p1     <= '0;
      mispredict_cnt_p1 <= '0;
      underflow_p1      <= 1'b0;
    end else begin
      upd_vld_p1 <= pop;
      flush_p1   <= mispredict;
      if (pop) begin
        upd_taken_p1  <= bus.res_taken;
        upd_pc_p1     <= q_pc[head];
        branch_cnt_p1 <= sat_inc(branch_cnt_p1);
      end
      if (mispredict) begin
        redirect_pc_p1    <= bus.res_taken ? bus.res_target : q_pc[head] + 32'd4;
        mispredict_cnt_p1 <= sat_inc(mispredict_cnt_p1);
      end
      if (underflow) underflow_p1 <= 1'b1;
    end
  end

  assign bus.upd_valid        = upd_vld_p1;
  assign bus.upd_taken        = upd_taken_p1;
  assign bus.upd_pc           = upd_pc_p1;
  assign bus.flush            = flush_p1;
  assign bus.redirect_pc      = redirect_pc_p1;
  assign bus.branch_count     = branch_cnt_p1;
  assign bus.mispredict_count = mispredict_cnt_p1;
  assign bus.underflow_err    = underflow_p1;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and randomized bench for branch_resolve_unit against a queue-based
// reference model of the prediction/resolution rules.
module tb_branch_resolve_unit;
  localparam int DEPTH          = 4;
  localparam int RECOVER_CYCLES = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_if bus ();

  branch_resolve_unit #(.DEPTH(DEPTH), .RECOVER_CYCLES(RECOVER_CYCLES)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    bit        taken;
    bit [31:0] pc;
    bit [31:0] tgt;
  } ent_t;

  ent_t      q[$];
  int        hold;
  bit [31:0] m_bc, m_mc, m_upd_pc, m_redir;
  bit        m_upd_valid, m_upd_taken, m_flush, m_under;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] sat1(input bit [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic bit model_ready();
    return (hold == 0) && (q.size() < DEPTH);
  endfunction

  task automatic model_reset();
    q.delete();
    hold = 0;
    m_bc = 0; m_mc = 0; m_upd_pc = 0; m_redir = 0;
    m_upd_valid = 0; m_upd_taken = 0; m_flush = 0; m_under = 0;
  endtask

  // Applies the resolution rules to the inputs present at a rising edge.
  task automatic model_edge();
    bit   accept;
    bit   mis;
    ent_t e;
    accept      = bus.pred_valid && model_ready();
    m_upd_valid = 0;
    m_flush     = 0;
    if (hold > 0) begin
      hold--;
    end else if (bus.res_valid) begin
      if (q.size() == 0) begin
        m_under = 1;
      end else begin
        e = q.pop_front();
        mis = (bus.res_taken != e.taken) || (bus.res_taken && bus.res_target != e.tgt);
        m_upd_valid = 1;
        m_upd_taken = bus.res_taken;
        m_upd_pc    = e.pc;
        m_bc        = sat1(m_bc);
        if (mis) begin
          m_flush = 1;
          m_redir = bus.res_taken ? bus.res_target : e.pc + 32'd4;
          m_mc    = sat1(m_mc);
          q.delete();
          hold    = RECOVER_CYCLES;
          accept  = 0;
        end
      end
    end
    if (accept) q.push_back('{bus.pred_taken, bus.pred_pc, bus.pred_target});
  endtask

  task automatic check_all();
    chk("pred_ready", {31'b0, bus.pred_ready}, {31'b0, model_ready()});
    chk("upd_valid", {31'b0, bus.upd_valid}, {31'b0, m_upd_valid});
    chk("flush", {31'b0, bus.flush}, {31'b0, m_flush});
    chk("branch_count", bus.branch_count, m_bc);
    chk("mispredict_count", bus.mispredict_count, m_mc);
    chk("underflow_err", {31'b0, bus.underflow_err}, {31'b0, m_under});
    if (m_upd_valid) begin
      chk("upd_taken", {31'b0, bus.upd_taken}, {31'b0, m_upd_taken});
      chk("upd_pc", bus.upd_pc, m_upd_pc);
    end
    if (m_flush) chk("redirect_pc", bus.redirect_pc, m_redir);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pred_ready"}, {31'b0, bus.pred_ready}, 32'd1);
    chk({tag, "_upd_valid"}, {31'b0, bus.upd_valid}, 32'd0);
    chk({tag, "_upd_taken"}, {31'b0, bus.upd_taken}, 32'd0);
    chk({tag, "_upd_pc"}, bus.upd_pc, 32'd0);
    chk({tag, "_flush"}, {31'b0, bus.flush}, 32'd0);
    chk({tag, "_redirect_pc"}, bus.redirect_pc, 32'd0);
    chk({tag, "_branch_count"}, bus.branch_count, 32'd0);
    chk({tag, "_mispredict_count"}, bus.mispredict_count, 32'd0);
    chk({tag, "_underflow_err"}, {31'b0, bus.underflow_err}, 32'd0);
  endtask

  task automatic drive(input bit pv, input bit pt, input bit [31:0] ppc, input bit [31:0] ptgt,
                       input bit rv, input bit rt, input bit [31:0] rtgt);
    bus.pred_valid  = pv;
    bus.pred_taken  = pt;
    bus.pred_pc     = ppc;
    bus.pred_target = ptgt;
    bus.res_valid   = rv;
    bus.res_taken   = rt;
    bus.res_target  = rtgt;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    bit        pv, pt, rv, rt;
    bit [31:0] ppc, ptgt, rtgt;

    idle();
    model_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    reset_n = 1'b1;

    // Correct taken prediction
    drive(1, 1, 32'h100, 32'h80, 0, 0, 32'h0); tick();
    drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h80);   tick();
    chk("t1_upd_valid", {31'b0, bus.upd_valid}, 32'd1);
    chk("t1_upd_pc", bus.upd_pc, 32'h100);
    chk("t1_flush", {31'b0, bus.flush}, 32'd0);
    chk("t1_branch_count", bus.branch_count, 32'd1);
    idle(); tick();
    chk("t1_upd_pulse", {31'b0, bus.upd_valid}, 32'd0);

    // Predicted not-taken, actually taken: flush and recovery window
    drive(1, 0, 32'h200, 32'h0, 0, 0, 32'h0); tick();
    drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h240); tick();
    chk("t2_flush", {31'b0, bus.flush}, 32'd1);
    chk("t2_redirect", bus.redirect_pc, 32'h240);
    chk("t2_mis_count", bus.mispredict_count, 32'd1);
    chk("t2_ready_c0", {31'b0, bus.pred_ready}, 32'd0);
    idle(); tick();
    chk("t2_ready_c1", {31'b0, bus.pred_ready}, 32'd0);
    tick();
    chk("t2_ready_c2", {31'b0, bus.pred_ready}, 32'd1);

    // Taken predicted, not taken actual; then wrong target
    drive(1, 1, 32'h300, 32'h340, 0, 0, 32'h0); tick();
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);     tick();
    chk("t3_redirect_nt", bus.redirect_pc, 32'h304);
    idle(); tick(); tick();
    drive(1, 1, 32'h300, 32'h340, 0, 0, 32'h0); tick();
    drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h350);   tick();
    chk("t3_redirect_tgt", bus.redirect_pc, 32'h350);
    idle(); tick(); tick();

    // Fill the queue, then overlapping push/pop and FIFO retirement order
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 32'h10 * i, 32'h0, 0, 0, 32'h0);
      tick();
    end
    chk("t4_full_ready", {31'b0, bus.pred_ready}, 32'd0);
    drive(1, 0, 32'h50, 32'h0, 1, 0, 32'h0); tick();
    chk("t4_pop0", bus.upd_pc, 32'h10);
    drive(1, 0, 32'h60, 32'h0, 1, 0, 32'h0); tick();
    chk("t4_pop1", bus.upd_pc, 32'h20);
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);  tick();
    chk("t4_pop2", bus.upd_pc, 32'h30);
    tick();
    chk("t4_pop3", bus.upd_pc, 32'h40);
    tick();
    chk("t4_pop4", bus.upd_pc, 32'h60);
    idle(); tick();

    // Mispredict with entries behind it; stale resolutions; underflow
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'h500 + 32'(4 * i), 32'h0, 0, 0, 32'h0);
      tick();
    end
    drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h900); tick();
    chk("t5_flush", {31'b0, bus.flush}, 32'd1);
    tick();
    chk("t5_stale0_err", {31'b0, bus.underflow_err}, 32'd0);
    tick();
    chk("t5_stale1_upd", {31'b0, bus.upd_valid}, 32'd0);
    tick();
    chk("t5_underflow", {31'b0, bus.underflow_err}, 32'd1);
    idle(); tick();

    // Asynchronous reset while recovering
    drive(1, 0, 32'h700, 32'h0, 0, 0, 32'h0); tick();
    drive(1, 0, 32'h704, 32'h0, 0, 0, 32'h0); tick();
    drive(0, 0, 32'h0, 32'h0, 1, 1, 32'hA00);  tick();
    idle();
    #3 reset_n = 1'b0;
    #1;
    check_reset("async_reset");
    model_reset();
    @(posedge clk);
    #2 reset_n = 1'b1;
    tick();
    chk("t6_ready_after", {31'b0, bus.pred_ready}, 32'd1);

    // Randomized traffic, biased toward correct predictions
    for (int i = 0; i < 400; i++) begin
      pv   = 1'($urandom_range(0, 1));
      pt   = 1'($urandom_range(0, 1));
      ppc  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      ptgt = ($urandom_range(0, 1) == 1) ? 32'h1000 : 32'h2000;
      rv   = ($urandom_range(0, 9) < 4);
      if (q.size() > 0 && $urandom_range(0, 9) < 7) begin
        rt   = q[0].taken;
        rtgt = q[0].tgt;
      end else begin
        rt   = 1'($urandom_range(0, 1));
        rtgt = ($urandom_range(0, 1) == 1) ? 32'h1000 : 32'h2000;
      end
      drive(pv, pt, ppc, ptgt, rv, rt, rtgt);
      tick();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
